// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: offset-binary capture, leaky-integrator DC removal, gain with
// saturation, and a four-deep valid/ready output pipeline that stalls as one unit.
module adc_sample_conditioner #(
  parameter int unsigned in_res     = 12,
  parameter int unsigned out_res    = 16,
  parameter int unsigned dc_shift   = 10,
  parameter int unsigned gain_shift = 4,
  parameter int unsigned drop_w     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adc_valid,
  input  logic [in_res-1:0]  adc_sample,
  input  logic               dc_en,
  output logic [out_res-1:0] out_sample,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sat_flag,
  output logic [drop_w-1:0]  drop_cnt
);

  localparam int unsigned AccW = in_res + dc_shift + 1;
  localparam int unsigned YW   = in_res + 1;
  localparam int unsigned ZW   = in_res + 1 + gain_shift;

  localparam logic signed [ZW-1:0] ZMax = ZW'((2 ** (out_res - 1)) - 1);
  localparam logic signed [ZW-1:0] ZMin = -ZMax - ZW'(1);
  localparam logic [out_res-1:0] OutMax = {1'b0, {(out_res - 1){1'b1}}};
  localparam logic [out_res-1:0] OutMin = {1'b1, {(out_res - 1){1'b0}}};

  logic                      s0_v_q, s1_v_q, s2_v_q, out_v_q;
  logic signed [in_res-1:0]  s0_x_q;
  logic signed [YW-1:0]      s1_y_q;
  logic [out_res-1:0]        s2_data_q, out_sample_q;
  logic signed [AccW-1:0]    acc_q;
  logic                      sat_q;
  logic [drop_w-1:0]         drop_q;

  logic                      en;
  logic signed [in_res-1:0]  x_d;
  logic signed [AccW-1:0]    dc_full;
  logic signed [YW-1:0]      y_d;
  logic signed [AccW-1:0]    acc_d;
  logic signed [ZW-1:0]      z;
  logic [out_res-1:0]        s2_data_d;
  logic                      clamp;

  always_comb begin
    en      = !out_v_q || out_ready;
    // Offset binary to two's complement is just an MSB flip.
    x_d     = {~adc_sample[in_res-1], adc_sample[in_res-2:0]};
    dc_full = acc_q >>> dc_shift;
    y_d     = YW'(s0_x_q);
    if (dc_en) y_d = YW'(s0_x_q) - dc_full[YW-1:0];
    acc_d   = acc_q + AccW'(y_d);

    z         = ZW'(s1_y_q) <<< gain_shift;
    clamp     = 1'b0;
    s2_data_d = z[out_res-1:0];
    if (z > ZMax) begin
      s2_data_d = OutMax;
      clamp     = 1'b1;
    end else if (z < ZMin) begin
      s2_data_d = OutMin;
      clamp     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v_q       <= 1'b0;
      s1_v_q       <= 1'b0;
      s2_v_q       <= 1'b0;
      out_v_q      <= 1'b0;
      s0_x_q       <= '0;
      s1_y_q       <= '0;
      s2_data_q    <= '0;
      out_sample_q <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      drop_q       <= '0;
    end else if (en) begin
      s0_v_q <= adc_valid;
      if (adc_valid) s0_x_q <= x_d;
      s1_v_q <= s0_v_q;
      s1_y_q <= y_d;
      if (s0_v_q && dc_en) acc_q <= acc_d;
      s2_v_q    <= s1_v_q;
      s2_data_q <= s2_data_d;
      if (s1_v_q && clamp) sat_q <= 1'b1;
      out_v_q      <= s2_v_q;
      out_sample_q <= s2_data_q;
    end else if (adc_valid && (drop_q != '1)) begin
      drop_q <= drop_q + drop_w'(1);
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_v_q;
  assign sat_flag   = sat_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed bench for adc_sample_conditioner: default instance plus a gain_shift=5 instance
// sharing the same stimulus.
module tb_adc_sample_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_valid;
  logic [11:0] adc_sample;
  logic        dc_en;
  logic        out_ready;
  logic [15:0] out_sample, out_sample5;
  logic        out_valid, out_valid5;
  logic        sat_flag, sat_flag5;
  logic [7:0]  drop_cnt, drop_cnt5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adc_sample_conditioner dut (
    .clk        (clk),
    .rst        (rst),
    .adc_valid  (adc_valid),
    .adc_sample (adc_sample),
    .dc_en      (dc_en),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_flag   (sat_flag),
    .drop_cnt   (drop_cnt)
  );

  adc_sample_conditioner #(.gain_shift(5)) dut5 (
    .clk        (clk),
    .rst        (rst),
    .adc_valid  (adc_valid),
    .adc_sample (adc_sample),
    .dc_en      (dc_en),
    .out_sample (out_sample5),
    .out_valid  (out_valid5),
    .out_ready  (out_ready),
    .sat_flag   (sat_flag5),
    .drop_cnt   (drop_cnt5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Bounded wait for out_valid; a timeout is reported as a failed check.
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !out_valid; i++) tick();
    check(tag, 32'(out_valid), 32'd1);
  endtask

  // One strobe, then consume the output once it arrives.
  task automatic send_one(input logic [11:0] code);
    adc_valid  = 1'b1;
    adc_sample = code;
    tick();
    adc_valid = 1'b0;
    wait_valid("send_valid");
  endtask

  logic signed [15:0] cur, prev, last;
  logic               mono_ok;
  logic [15:0]        exp_bp[4];

  initial begin
    rst        = 1'b1;
    adc_valid  = 1'b0;
    adc_sample = '0;
    dc_en      = 1'b0;
    out_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sample", 32'(out_sample), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Latency: captured on edge 0, visible after edge 3.
    adc_valid  = 1'b1;
    adc_sample = 12'h800;
    tick();
    adc_valid = 1'b0;
    tick();
    tick();
    check("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("mid_code", 32'(out_sample), 32'h0000);
    check("mid_sat", 32'(sat_flag), 32'd0);
    tick();
    check("consumed", 32'(out_valid), 32'd0);

    // Scaling and saturation, DC removal bypassed.
    send_one(12'hFFF);
    check("full_pos", 32'(out_sample), 32'h7FF0);
    check("g5_full_pos", 32'(out_sample5), 32'h7FFF);
    check("g5_sat_set", 32'(sat_flag5), 32'd1);
    tick();
    send_one(12'h000);
    check("full_neg", 32'(out_sample), 32'h8000);
    tick();
    send_one(12'h801);
    check("one_lsb", 32'(out_sample), 32'h0010);
    tick();
    send_one(12'h800);
    check("g5_mid", 32'(out_sample5), 32'h0000);
    check("g5_sat_sticky", 32'(sat_flag5), 32'd1);
    check("g4_no_sat", 32'(sat_flag), 32'd0);
    tick();

    // Backpressure: four fill the pipeline, the last two strobes are dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      adc_valid  = 1'b1;
      adc_sample = 12'h801 + 12'(i);
      tick();
    end
    adc_valid = 1'b0;
    check("bp_drop", 32'(drop_cnt), 32'd2);
    tick();
    tick();
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_data", 32'(out_sample), 32'h0010);
    exp_bp[0] = 16'h0010;
    exp_bp[1] = 16'h0020;
    exp_bp[2] = 16'h0030;
    exp_bp[3] = 16'h0040;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_valid", 32'(out_valid), 32'd1);
      check("bp_drain_data", 32'(out_sample), 32'(exp_bp[k]));
      tick();
    end
    check("bp_empty", 32'(out_valid), 32'd0);

    // DC removal on a constant input converges towards zero.
    do_reset();
    check("rst_sat5", 32'(sat_flag5), 32'd0);
    dc_en      = 1'b1;
    adc_valid  = 1'b1;
    adc_sample = 12'h900;
    tick();
    wait_valid("dc_first_valid");
    check("dc_first", 32'(out_sample), 32'h1000);
    mono_ok = 1'b1;
    prev    = 16'sh7FFF;
    last    = '0;
    for (int n = 0; n < 8192; n++) begin
      cur = out_sample;
      if (!out_valid || cur > prev || cur < 0) mono_ok = 1'b0;
      prev = cur;
      last = cur;
      tick();
    end
    adc_valid = 1'b0;
    check("dc_monotonic", 32'(mono_ok), 32'd1);
    check("dc_settled", 32'(last <= 16'sd32 && last >= -16'sd32), 32'd1);

    // Drop counter saturates and holds.
    do_reset();
    dc_en     = 1'b0;
    out_ready = 1'b0;
    adc_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("drop_sat", 32'(drop_cnt), 32'hFF);
    for (int i = 0; i < 10; i++) tick();
    check("drop_hold", 32'(drop_cnt), 32'hFF);
    adc_valid = 1'b0;

    // Reset mid-stream with a full pipeline and a nonzero accumulator.
    do_reset();
    dc_en      = 1'b1;
    adc_valid  = 1'b1;
    adc_sample = 12'h900;
    for (int i = 0; i < 6; i++) tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_drop", 32'(drop_cnt), 32'd2);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    adc_valid = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_sat", 32'(sat_flag), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("rst_strobe_ignored", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send_one(12'h900);
    check("acc_cleared", 32'(out_sample), 32'h1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
